// File: rtl/led_prog_loader.sv
// led_prog_loader
//   Instruction-memory responder for the LED pattern CPU core. Holds a
//   DEPTH x 16 program RAM ({pattern_or_target[15:8], duration[7:0]},
//   duration==0 is a jump), serves the core's zero-latency read port and
//   accepts a valid/ready write stream that reloads the program while the
//   core is held in reset.
//
//   Build option: LED_PROG_AUTO_LOOP_EN
//     defined   - the seal cycle appends a jump-to-0 word after the program
//                 when there is room for it
//     undefined - the seal cycle writes nothing; the program supplies its own jump
//
//   Ports
//     clk        system clock
//     rst        asynchronous active-low reset
//     load_start single-cycle pulse, begins/restarts a program load
//     wr_valid   write word present
//     wr_data    instruction word to store
//     wr_last    marks the final word of the program (sampled with wr_valid)
//     wr_ready   word accepted this cycle when wr_valid is also high
//     addrRd     core read address
//     dataRd     instruction at addrRd (16'h0000 while the core is in reset)
//     core_rst   active-high reset to the core
//     busy       load in progress
//     prog_len   words in the current program (ADDR_W+1 bits, holds DEPTH)
//     error      last load overflowed the RAM
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_EMPTY | no valid program, core held in reset
//   S_LOAD  | accepting words, core held in reset
//   S_SEAL  | one cycle after the last word (optional loop word append)
//   S_RUN   | core released, executing from address 0
//   S_ERR   | program overflowed the RAM, core held in reset

module led_prog_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              wr_valid,
   input  logic [15:0]       wr_data,
   input  logic              wr_last,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] addrRd,
   output logic [15:0]       dataRd,
   output logic              core_rst,
   output logic              busy,
   output logic [ADDR_W:0]   prog_len,
   output logic              error
);

   typedef enum logic [2:0] {
      S_EMPTY,
      S_LOAD,
      S_SEAL,
      S_RUN,
      S_ERR
   } state_t;

   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
   localparam logic [ADDR_W:0]   LEN_ONE  = 1;
`ifdef LED_PROG_AUTO_LOOP_EN
   localparam logic [ADDR_W:0]   LEN_FULL = (ADDR_W+1)'(DEPTH);
`endif

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   wr_ptr, wr_ptr_nxt;
   logic [ADDR_W:0]     len_q, len_nxt;
   logic                accept;
   logic                mem_we;
   logic [15:0]         mem_wdata;
   logic [15:0]         mem [DEPTH];

   assign wr_ready = (state == S_LOAD) && !load_start;
   assign accept   = wr_ready && wr_valid;

   always_comb begin
      state_nxt  = state;
      wr_ptr_nxt = wr_ptr;
      len_nxt    = len_q;
      mem_we     = 1'b0;
      mem_wdata  = wr_data;
      if (load_start) begin
         // restart wins over any same-cycle write
         state_nxt  = S_LOAD;
         wr_ptr_nxt = '0;
         len_nxt    = '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (accept) begin
                  mem_we     = 1'b1;
                  wr_ptr_nxt = wr_ptr + PTR_ONE;
                  len_nxt    = len_q + LEN_ONE;
                  if (wr_last)
                     state_nxt = S_SEAL;
                  else if (wr_ptr == PTR_LAST)
                     state_nxt = S_ERR;
               end
            end
            S_SEAL: begin
`ifdef LED_PROG_AUTO_LOOP_EN
               // a full RAM needs no loop word: the core's address wraps to 0
               if (len_q < LEN_FULL) begin
                  mem_we    = 1'b1;
                  mem_wdata = 16'h0000;
                  len_nxt   = len_q + LEN_ONE;
               end
`endif
               state_nxt = S_RUN;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_EMPTY;
         wr_ptr <= '0;
         len_q  <= '0;
      end else begin
         state  <= state_nxt;
         wr_ptr <= wr_ptr_nxt;
         len_q  <= len_nxt;
      end
   end

   // RAM survives reset; writes are gated by state, which is forced to S_EMPTY
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[wr_ptr] <= mem_wdata;
   end

   assign core_rst = (state != S_RUN);
   assign busy     = (state == S_LOAD) || (state == S_SEAL);
   assign error    = (state == S_ERR);
   assign prog_len = len_q;
   assign dataRd   = core_rst ? 16'h0000 : mem[addrRd];

endmodule

// File: tb/tb_led_prog_loader.sv
module tb_led_prog_loader;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              load_start = 1'b0;
   logic              wr_valid = 1'b0;
   logic [15:0]       wr_data = 16'h0;
   logic              wr_last = 1'b0;
   logic              wr_ready;
   logic [ADDR_W-1:0] addrRd = '0;
   logic [15:0]       dataRd;
   logic              core_rst;
   logic              busy;
   logic [ADDR_W:0]   prog_len;
   logic              error;

   led_prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .wr_valid(wr_valid),
      .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
      .addrRd(addrRd), .dataRd(dataRd), .core_rst(core_rst), .busy(busy),
      .prog_len(prog_len), .error(error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model: what the RAM must hold and how long the program is
   logic [15:0] model_mem [DEPTH];
   bit          model_known [DEPTH];
   int          wr_count = 0;
   int          exp_len = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; load_start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
      #7;
      rst = 1'b1;
      tick();
      wr_count = 0;
      exp_len = 0;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      wr_valid = 1'($urandom_range(0, 1));
      wr_data = 16'($urandom);
      #1;
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL start_wr_ready: got %b expected 0", wr_ready); end
      tick();
      load_start = 1'b0;
      wr_valid = 1'b0;
      wr_count = 0;
      exp_len = 0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy: got %b expected 1", busy); end
      checks++; if (core_rst !== 1'b1) begin failures++; $display("FAIL start_core_rst: got %b expected 1", core_rst); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL start_error: got %b expected 0", error); end
      checks++; if (prog_len !== 9'd0) begin failures++; $display("FAIL start_len: got %0d expected 0", prog_len); end
   endtask

   task automatic send_word(input logic [15:0] d, input bit last, input int gap);
      int guard;
      guard = 0;
      wr_valid = 1'b1; wr_data = d; wr_last = last;
      #1;
      while (!wr_ready && guard < 20) begin
         tick();
         guard++;
      end
      if (guard >= 20) begin
         checks++; failures++;
         $display("FAIL send_timeout: wr_ready stayed %b expected 1", wr_ready);
         wr_valid = 1'b0; wr_last = 1'b0;
         return;
      end
      tick();
      model_mem[wr_count] = d;
      model_known[wr_count] = 1'b1;
      wr_count++;
      exp_len = wr_count;
      wr_valid = 1'b0; wr_last = 1'b0;
      repeat (gap) begin
         wr_data = 16'($urandom);
         tick();
      end
   endtask

   task automatic check_ram();
      for (int i = 0; i < DEPTH; i++) begin
         if (model_known[i]) begin
            addrRd = 8'(i);
            #1;
            checks++;
            if (dataRd !== model_mem[i]) begin
               failures++;
               $display("FAIL ram[%0d]: got %h expected %h", i, dataRd, model_mem[i]);
            end
         end
      end
   endtask

   // called right after the wr_last word was accepted
   task automatic finish_seal();
      checks++; if (busy !== 1'b1 || core_rst !== 1'b1) begin failures++; $display("FAIL seal: got busy=%b core_rst=%b expected 1 1", busy, core_rst); end
      tick();
`ifdef LED_PROG_AUTO_LOOP_EN
      if (exp_len < DEPTH) begin
         model_mem[exp_len] = 16'h0000;
         model_known[exp_len] = 1'b1;
         exp_len++;
      end
`endif
      checks++; if (core_rst !== 1'b0) begin failures++; $display("FAIL run_core_rst: got %b expected 0", core_rst); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL run_busy: got %b expected 0", busy); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL run_error: got %b expected 0", error); end
      checks++; if (int'(prog_len) !== exp_len) begin failures++; $display("FAIL run_len: got %0d expected %0d", prog_len, exp_len); end
      check_ram();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (core_rst !== 1'b1) begin failures++; $display("FAIL rst_core_rst: got %b expected 1", core_rst); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error: got %b expected 0", error); end
      checks++; if (prog_len !== 9'd0) begin failures++; $display("FAIL rst_len: got %0d expected 0", prog_len); end
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready: got %b expected 0", wr_ready); end
      for (int i = 0; i < DEPTH; i++) begin
         addrRd = 8'(i);
         #1;
         checks++; if (dataRd !== 16'h0000) begin failures++; $display("FAIL rst_dataRd[%0d]: got %h expected 0000", i, dataRd); end
      end
      // writes while idle must be ignored
      repeat (3) begin
         wr_valid = 1'b1; wr_data = 16'($urandom); wr_last = 1'($urandom_range(0, 1));
         tick();
      end
      wr_valid = 1'b0; wr_last = 1'b0;
      checks++; if (prog_len !== 9'd0 || busy !== 1'b0) begin failures++; $display("FAIL idle_write: got len=%0d busy=%b expected 0 0", prog_len, busy); end
   endtask

   task automatic test_back_to_back();
      start_load();
      send_word(16'h0103, 1'b0, 0);
      send_word(16'h0205, 1'b0, 0);
      send_word(16'h0000, 1'b1, 0);
      finish_seal();
      addrRd = 8'd1;
      #1;
      checks++; if (dataRd !== 16'h0205) begin failures++; $display("FAIL b2b_addr1: got %h expected 0205", dataRd); end
   endtask

   task automatic test_random_loads();
      for (int n = 0; n < 5; n++) begin
         int len;
         len = (n == 0) ? 1 : int'($urandom_range(2, 24));
         start_load();
         for (int k = 0; k < len; k++) begin
            logic [15:0] d;
            d = 16'($urandom) | 16'h0100;
            if (k == len - 1) send_word(d, 1'b1, 0);
            else send_word(d, 1'b0, int'($urandom_range(0, 2)));
         end
         finish_seal();
      end
   endtask

   task automatic test_auto_loop();
      start_load();
      send_word(16'h0103, 1'b0, 0);
      send_word(16'h0205, 1'b1, 0);
      finish_seal();
      addrRd = 8'd2;
      #1;
`ifdef LED_PROG_AUTO_LOOP_EN
      checks++; if (dataRd !== 16'h0000 || prog_len !== 9'd3) begin failures++; $display("FAIL loop_word: got %h len=%0d expected 0000 3", dataRd, prog_len); end
`else
      checks++; if (prog_len !== 9'd2) begin failures++; $display("FAIL loop_len: got %0d expected 2", prog_len); end
`endif
   endtask

   task automatic test_overflow();
      start_load();
      for (int k = 0; k < DEPTH; k++) send_word(16'($urandom), 1'b0, 0);
      wr_valid = 1'b1; wr_data = 16'($urandom);
      #1;
      checks++; if (error !== 1'b1) begin failures++; $display("FAIL ovf_error: got %b expected 1", error); end
      checks++; if (core_rst !== 1'b1) begin failures++; $display("FAIL ovf_core_rst: got %b expected 1", core_rst); end
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL ovf_wr_ready: got %b expected 0", wr_ready); end
      checks++; if (prog_len !== 9'd256) begin failures++; $display("FAIL ovf_len: got %0d expected 256", prog_len); end
      tick();
      wr_valid = 1'b0;
      checks++; if (error !== 1'b1 || prog_len !== 9'd256) begin failures++; $display("FAIL ovf_hold: got err=%b len=%0d expected 1 256", error, prog_len); end
      start_load();
      send_word(16'h1122, 1'b0, 0);
      send_word(16'h3344, 1'b1, 0);
      finish_seal();
   endtask

   task automatic test_full_last();
      start_load();
      for (int k = 0; k < DEPTH - 1; k++) send_word(16'($urandom), 1'b0, 0);
      send_word(16'h0000, 1'b1, 0);
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL full_not_err: got %b expected 0", error); end
      finish_seal();
   endtask

   task automatic test_restart();
      start_load();
      send_word(16'h5501, 1'b0, 0);
      send_word(16'h6602, 1'b0, 0);
      load_start = 1'b1; wr_valid = 1'b1; wr_data = 16'hAA01; wr_last = 1'b0;
      #1;
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL restart_ready: got %b expected 0", wr_ready); end
      tick();
      load_start = 1'b0; wr_valid = 1'b0;
      wr_count = 0; exp_len = 0;
      checks++; if (prog_len !== 9'd0 || busy !== 1'b1) begin failures++; $display("FAIL restart_state: got len=%0d busy=%b expected 0 1", prog_len, busy); end
      send_word(16'h7703, 1'b0, 1);
      send_word(16'h8804, 1'b1, 0);
      finish_seal();
      addrRd = 8'd0;
      #1;
      checks++; if (dataRd !== 16'h7703) begin failures++; $display("FAIL restart_addr0: got %h expected 7703", dataRd); end
   endtask

   task automatic test_midload_reset();
      start_load();
      for (int k = 0; k < 5; k++) send_word(16'($urandom) | 16'h0100, 1'b0, 0);
      #2;
      rst = 1'b0;
      #1;
      checks++; if (core_rst !== 1'b1) begin failures++; $display("FAIL mrst_core_rst: got %b expected 1", core_rst); end
      checks++; if (prog_len !== 9'd0 || busy !== 1'b0) begin failures++; $display("FAIL mrst_state: got len=%0d busy=%b expected 0 0", prog_len, busy); end
      #3;
      rst = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         addrRd = 8'(i);
         #1;
         checks++; if (dataRd !== 16'h0000) begin failures++; $display("FAIL mrst_dataRd[%0d]: got %h expected 0000", i, dataRd); end
      end
      wr_count = 0; exp_len = 0;
      start_load();
      send_word(16'h0901, 1'b0, 0);
      send_word(16'h0000, 1'b1, 0);
      finish_seal();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = 16'h0;
         model_known[i] = 1'b0;
      end
      test_reset();
      test_back_to_back();
      test_random_loads();
      test_auto_loop();
      test_overflow();
      test_full_last();
      test_restart();
      test_midload_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/led_prog_loader.md
Name: led_prog_loader

Overview:
- Instruction-memory responder for the LED pattern CPU core.
- Holds a DEPTH x 16 program RAM. Each word is {pattern_or_target[15:8], duration[7:0]}, and duration==0 means jump to the target.
- Serves the core's combinational read port (addrRd in, dataRd out).
- Provides a valid/ready write stream to reload the program at run time, and holds the core in reset while a program is loaded.

Parameters:
- ADDR_W, 8, address width of the program RAM (must match the core's addrRd width).
- DEPTH, 256, number of words; fixed to 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- load_start  in  1  single-cycle pulse; begins (or restarts) a program load.
- wr_valid  in  1  write word present.
- wr_data  in  16  instruction word to store.
- wr_last  in  1  qualifies the final word of the program; sampled with wr_valid.
- wr_ready  out  1  block accepts wr_data this cycle.
- addrRd  in  ADDR_W  core read address.
- dataRd  out  16  instruction at addrRd.
- core_rst  out  1  active-high reset to the core.
- busy  out  1  load in progress.
- prog_len  out  ADDR_W+1  words in the current program.
- error  out  1  last load overflowed.

Behaviour:
- Reset (rst=0, asynchronous):
  - State enters EMPTY; wr_ptr=0.
  - Outputs: prog_len=0, error=0, core_rst=1, busy=0, wr_ready=0.
  - RAM contents are not cleared.
- Write handshake: a word is accepted on a posedge where wr_valid && wr_ready. wr_ready is combinational: 1 only in LOAD and load_start=0.
- An accepted word is written to RAM[wr_ptr] at that edge. Then wr_ptr++ and prog_len++.
- Read port:
  - dataRd = RAM[addrRd], combinational and zero-latency, when core_rst=0.
  - dataRd = 16'h0000 (jump to 0) when core_rst=1.
- States:
  - EMPTY:
    - core_rst=1. Waits for load_start.
  - LOAD:
    - core_rst=1, busy=1.
    - Entered on load_start from any state: wr_ptr=0, prog_len=0, error=0.
    - An accepted word with wr_last=1 goes to SEAL.
    - An accepted word at wr_ptr==DEPTH-1 with wr_last=0 goes to ERR.
  - SEAL:
    - One cycle, busy=1, core_rst=1.
    - Action is defined under Optional Feature.
    - Then goes to RUN.
  - RUN:
    - core_rst=0, busy=0.
    - The core executes from address 0, because it was held in reset throughout the load.
  - ERR:
    - core_rst=1, error=1, wr_ready=0. prog_len=DEPTH.
    - Leaves only on load_start (to LOAD).
- Boundary conditions:
  - load_start has priority over a same-cycle write: the word is not accepted and wr_ptr is reset.
  - load_start during LOAD restarts the load.
  - load_start during RUN re-asserts core_rst on the next edge.
  - wr_valid outside LOAD is ignored.
  - A one-word program (first word has wr_last=1) is legal: prog_len=1.
  - wr_last on the word at DEPTH-1 is legal: prog_len=DEPTH, goes to SEAL, not ERR.
  - If rst asserts mid-load, the partially written RAM is kept, but the state is EMPTY. A new load is required before the core runs.
  - prog_len is ADDR_W+1 bits wide so it can hold DEPTH without wrapping.

Optional Feature:
- Macro LED_PROG_AUTO_LOOP_EN.
- Defined:
  - In SEAL, if prog_len<DEPTH, write 16'h0000 (jump to 0) at RAM[wr_ptr] and increment prog_len.
  - If prog_len==DEPTH, write nothing; the core's address wrap returns it to 0.
- Undefined:
  - SEAL writes nothing. The program must supply its own jump.

Test Plan:
- Reset then idle → core_rst=1, dataRd=0000, prog_len=0, busy=0, error=0 while addrRd sweeps 0..255.
- Load 3 words with back-to-back wr_valid: 0x0103, 0x0205, 0x0000 (last) → RAM[0..2] hold them, prog_len=3. core_rst falls 2 cycles after the last accept (SEAL then RUN). With addrRd=1, dataRd=0x0205.
- Same as above with LED_PROG_AUTO_LOOP_EN, last word 0x0205 → RAM[2]=0x0000, prog_len=3. Without the macro: prog_len=2 and RAM[2] is unchanged.
- Stream 256 words with wr_last=0 → ERR: error=1, core_rst=1, wr_ready=0. A subsequent load_start clears error and busy=1.
- During LOAD, after 2 words accepted, assert load_start with wr_valid=1, data 0xAA01 → word dropped, prog_len=0. The next accepted word lands at address 0.
- Pull rst low mid-load (after 5 words) → immediate EMPTY: core_rst=1, prog_len=0. dataRd=0000 until a new load completes.
